// File: rtl/bypass_network_if.sv
// Bus bundle between decode/regfile read and the bypass network.
interface bypass_network_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LANES  = 2,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned STAGES = 3,
    parameter int unsigned RADDR  = 5,
    parameter int unsigned SELW   = $clog2(STAGES*LANES+1)
);
    logic                            stall_i;
    logic                            flush_i;
    logic [LANES-1:0]                iss_valid_i;
    logic [LANES*RADDR-1:0]          iss_rd_i;
    logic [LANES-1:0]                iss_we_i;
    logic [LANES-1:0]                iss_load_i;
    logic [LANES*NSRC*RADDR-1:0]     src_addr_i;
    logic [LANES*NSRC*WIDTH-1:0]     rf_data_i;
    logic [STAGES*LANES*WIDTH-1:0]   stage_data_i;
    logic [LANES*NSRC*WIDTH-1:0]     opnd_o;
    logic [LANES*NSRC*SELW-1:0]      fwd_sel_o;
    logic                            hazard_o;

    modport master (
        output stall_i, flush_i, iss_valid_i, iss_rd_i, iss_we_i, iss_load_i,
        output src_addr_i, rf_data_i, stage_data_i,
        input  opnd_o, fwd_sel_o, hazard_o
    );

    modport slave (
        input  stall_i, flush_i, iss_valid_i, iss_rd_i, iss_we_i, iss_load_i,
        input  src_addr_i, rf_data_i, stage_data_i,
        output opnd_o, fwd_sel_o, hazard_o
    );
endinterface

// File: rtl/bypass_network.sv
// Operand forwarding unit: tracks in-flight destination tags per lane and stage,
// steers each source to the youngest matching result and flags load-use and
// intra-bundle hazards.
module bypass_network #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned LANES  = 2,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned STAGES = 3,
    parameter int unsigned RADDR  = 5,
    parameter int unsigned SELW   = $clog2(STAGES*LANES+1)
) (
    input  logic             clk,
    input  logic             rst,
    bypass_network_if.slave  bus
);
    localparam int unsigned NENT = STAGES * LANES;
    localparam int unsigned NOPS = LANES * NSRC;

    typedef struct packed {
        logic             v;
        logic [RADDR-1:0] rd;
        logic             we;
        logic             ld;
    } tag_t;

    tag_t tags     [NENT];
    tag_t tags_nxt [NENT];

    logic                        hazard;
    logic [NOPS*WIDTH-1:0]       opnd;
    logic [NOPS*SELW-1:0]        sel;

    // Operand steering and hazard detection against the current tag pipe.
    always_comb begin
        logic [RADDR-1:0] src;
        logic             hit;
        logic             win_ld;
        logic             op_haz;
        int unsigned      win;
        int unsigned      op;
        int unsigned      s;
        int unsigned      e;

        opnd   = '0;
        sel    = '0;
        hazard = 1'b0;
        src    = '0;
        hit    = 1'b0;
        win_ld = 1'b0;
        op_haz = 1'b0;
        win    = 0;
        op     = 0;
        s      = 0;
        e      = 0;

        for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned n = 0; n < NSRC; n++) begin
                op     = l * NSRC + n;
                src    = bus.src_addr_i[op*RADDR +: RADDR];
                hit    = 1'b0;
                win_ld = 1'b0;
                win    = 0;

                // Scan oldest to youngest so the last hit is the winner.
                for (int unsigned si = 0; si < STAGES; si++) begin
                    s = STAGES - 1 - si;
                    for (int unsigned k = 0; k < LANES; k++) begin
                        e = s * LANES + k;
                        if (tags[e].v && tags[e].we && (src != '0) && (tags[e].rd == src)) begin
                            hit    = 1'b1;
                            win    = e;
                            win_ld = tags[e].ld && (s == 0);
                        end
                    end
                end

                op_haz = hit && win_ld;

                // Earlier lanes in the same bundle produce values not yet available.
                for (int unsigned k = 0; k < l; k++) begin
                    if (bus.iss_valid_i[k] && bus.iss_we_i[k] && (src != '0) &&
                        (bus.iss_rd_i[k*RADDR +: RADDR] == src)) begin
                        op_haz = 1'b1;
                    end
                end

                hazard = hazard | (op_haz && bus.iss_valid_i[l]);

                if (hit && !win_ld) begin
                    sel[op*SELW +: SELW]   = SELW'(win + 1);
                    opnd[op*WIDTH +: WIDTH] = bus.stage_data_i[win*WIDTH +: WIDTH];
                end else begin
                    sel[op*SELW +: SELW]   = '0;
                    opnd[op*WIDTH +: WIDTH] = bus.rf_data_i[op*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign bus.opnd_o    = opnd;
    assign bus.fwd_sel_o = sel;
    assign bus.hazard_o  = hazard;

    // Next tag-pipe contents: flush clears, stall holds, hazard inserts a bubble.
    always_comb begin
        for (int unsigned i = 0; i < NENT; i++) begin
            tags_nxt[i] = tags[i];
        end
        if (bus.flush_i) begin
            for (int unsigned i = 0; i < NENT; i++) begin
                tags_nxt[i].v = 1'b0;
            end
        end else if (!bus.stall_i) begin
            for (int unsigned s = 1; s < STAGES; s++) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    tags_nxt[s*LANES+l] = tags[(s-1)*LANES+l];
                end
            end
            for (int unsigned l = 0; l < LANES; l++) begin
                if (hazard) begin
                    tags_nxt[l] = '0;
                end else begin
                    tags_nxt[l].v  = bus.iss_valid_i[l];
                    tags_nxt[l].rd = bus.iss_rd_i[l*RADDR +: RADDR];
                    tags_nxt[l].we = bus.iss_we_i[l];
                    tags_nxt[l].ld = bus.iss_load_i[l];
                end
            end
        end
    end

    // Tag pipe register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NENT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NENT; i++) begin
                tags[i] <= tags_nxt[i];
            end
        end
    end
endmodule

// File: tb/tb_bypass_network.sv
// Directed, table-driven bench for bypass_network.
module tb_bypass_network;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned LANES  = 2;
    localparam int unsigned NSRC   = 2;
    localparam int unsigned STAGES = 3;
    localparam int unsigned RADDR  = 5;
    localparam int unsigned SELW   = 3;
    localparam int unsigned NOPS   = LANES * NSRC;
    localparam int unsigned NROWS  = 23;

    typedef struct {
        logic       stall;
        logic       flush;
        logic [1:0] v;
        logic [1:0] we;
        logic [1:0] ld;
        logic [4:0] rd0, rd1;
        logic [4:0] s00, s01, s10, s11;
        logic       hz;
        logic [2:0] e00, e01, e10, e11;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    vec_t tbl [NROWS];

    bypass_network_if #(.WIDTH(WIDTH), .LANES(LANES), .NSRC(NSRC),
                        .STAGES(STAGES), .RADDR(RADDR), .SELW(SELW)) bus ();

    bypass_network #(.WIDTH(WIDTH), .LANES(LANES), .NSRC(NSRC),
                     .STAGES(STAGES), .RADDR(RADDR), .SELW(SELW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic stall, logic flush, logic [1:0] v, logic [1:0] we,
                                logic [1:0] ld, logic [4:0] rd0, logic [4:0] rd1,
                                logic [4:0] s00, logic [4:0] s01, logic [4:0] s10,
                                logic [4:0] s11, logic hz, logic [2:0] e00,
                                logic [2:0] e01, logic [2:0] e10, logic [2:0] e11);
        vec_t r;
        r.stall = stall; r.flush = flush; r.v = v; r.we = we; r.ld = ld;
        r.rd0 = rd0; r.rd1 = rd1;
        r.s00 = s00; r.s01 = s01; r.s10 = s10; r.s11 = s11;
        r.hz = hz; r.e00 = e00; r.e01 = e01; r.e10 = e10; r.e11 = e11;
        return r;
    endfunction

    function automatic logic [31:0] rf_val(int unsigned op);
        return 32'h1000_0000 | 32'(op);
    endfunction

    function automatic logic [31:0] st_val(int unsigned idx);
        return 32'hA000_0000 | 32'(idx);
    endfunction

    task automatic apply(input vec_t r);
        bus.stall_i     = r.stall;
        bus.flush_i     = r.flush;
        bus.iss_valid_i = r.v;
        bus.iss_we_i    = r.we;
        bus.iss_load_i  = r.ld;
        bus.iss_rd_i    = {r.rd1, r.rd0};
        bus.src_addr_i  = {r.s11, r.s10, r.s01, r.s00};
    endtask

    task automatic check(input string name, input vec_t r);
        logic [2:0]  esel [NOPS];
        logic [2:0]  asel;
        logic [31:0] eop;
        logic [31:0] aop;
        esel[0] = r.e00; esel[1] = r.e01; esel[2] = r.e10; esel[3] = r.e11;
        checks++;
        if (bus.hazard_o === r.hz) passes++;
        else $display("FAIL %s hazard: got %b want %b", name, bus.hazard_o, r.hz);
        for (int unsigned op = 0; op < NOPS; op++) begin
            asel = bus.fwd_sel_o[op*SELW +: SELW];
            aop  = bus.opnd_o[op*WIDTH +: WIDTH];
            eop  = (esel[op] == 3'd0) ? rf_val(op) : st_val(32'(esel[op]) - 1);
            checks++;
            if (asel === esel[op]) passes++;
            else $display("FAIL %s sel[%0d]: got %0d want %0d", name, op, asel, esel[op]);
            checks++;
            if (aop === eop) passes++;
            else $display("FAIL %s opnd[%0d]: got %h want %h", name, op, aop, eop);
        end
    endtask

    initial begin
        //            st fl v      we     ld     rd0 rd1 s00 s01 s10 s11 hz e00 e01 e10 e11
        tbl[0]  = mk(0, 0, 2'b01, 2'b01, 2'b00, 5,  0,  31, 0,  0,  0,  0, 0,  0,  0,  0);
        tbl[1]  = mk(0, 0, 2'b10, 2'b00, 2'b00, 0,  0,  0,  0,  5,  0,  0, 0,  0,  1,  0);
        tbl[2]  = mk(0, 0, 2'b01, 2'b01, 2'b01, 7,  0,  5,  0,  0,  0,  0, 3,  0,  0,  0);
        tbl[3]  = mk(0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  5,  7,  0,  0,  1, 5,  0,  0,  0);
        tbl[4]  = mk(0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  5,  7,  0,  0,  0, 0,  3,  0,  0);
        tbl[5]  = mk(0, 0, 2'b11, 2'b11, 2'b00, 3,  3,  7,  0,  0,  0,  0, 5,  0,  0,  0);
        tbl[6]  = mk(0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  3,  0,  0,  3,  0, 2,  0,  0,  2);
        tbl[7]  = mk(0, 0, 2'b01, 2'b01, 2'b00, 0,  0,  0,  0,  3,  0,  0, 0,  0,  4,  0);
        tbl[8]  = mk(0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  0,  3,  0,  0,  0, 0,  6,  0,  0);
        tbl[9]  = mk(0, 0, 2'b11, 2'b01, 2'b00, 9,  0,  0,  0,  9,  0,  1, 0,  0,  0,  0);
        tbl[10] = mk(0, 0, 2'b01, 2'b01, 2'b00, 9,  0,  0,  0,  9,  0,  0, 0,  0,  0,  0);
        tbl[11] = mk(0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  9,  0,  0,  0,  0, 1,  0,  0,  0);
        tbl[12] = mk(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,  9,  0,  0,  0,  0, 3,  0,  0,  0);
        tbl[13] = mk(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,  9,  0,  0,  0,  0, 3,  0,  0,  0);
        tbl[14] = mk(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,  9,  0,  0,  0,  0, 3,  0,  0,  0);
        tbl[15] = mk(0, 1, 2'b00, 2'b00, 2'b00, 0,  0,  9,  0,  0,  0,  0, 3,  0,  0,  0);
        tbl[16] = mk(0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  9,  0,  0,  0,  0, 0,  0,  0,  0);
        tbl[17] = mk(0, 0, 2'b01, 2'b01, 2'b01, 10, 0,  0,  0,  0,  0,  0, 0,  0,  0,  0);
        tbl[18] = mk(1, 0, 2'b01, 2'b00, 2'b00, 0,  0,  10, 0,  0,  0,  1, 0,  0,  0,  0);
        tbl[19] = mk(0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  10, 0,  0,  0,  1, 0,  0,  0,  0);
        tbl[20] = mk(0, 0, 2'b01, 2'b00, 2'b00, 0,  0,  10, 0,  0,  0,  0, 3,  0,  0,  0);
        tbl[21] = mk(0, 0, 2'b11, 2'b11, 2'b00, 12, 13, 12, 0,  0,  13, 0, 0,  0,  0,  0);
        tbl[22] = mk(0, 0, 2'b11, 2'b10, 2'b00, 14, 15, 0,  0,  0,  14, 0, 0,  0,  0,  0);

        for (int unsigned op = 0; op < NOPS; op++)
            bus.rf_data_i[op*WIDTH +: WIDTH] = rf_val(op);
        for (int unsigned i = 0; i < STAGES*LANES; i++)
            bus.stage_data_i[i*WIDTH +: WIDTH] = st_val(i);

        // Reset with an idle bundle, then confirm the empty tag pipe.
        rst = 1'b1;
        apply(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5, 7, 3, 9, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check("reset", mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 5, 7, 3, 9, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < int'(NROWS); i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            check($sformatf("row%0d", i), tbl[i]);
        end

        // Reset in the middle of a stall clears the producer tag.
        @(negedge clk);
        apply(mk(0, 0, 2'b01, 2'b01, 2'b00, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        apply(mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        check("rst_stall_pre", mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 20, 0, 0, 0, 0, 1, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        apply(mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("rst_stall_post", mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
